// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, stage payload type and parameter check for cla_pipe_adder
package cla_pkg;

  // Operation select encoding on the sub input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the stage payload can carry; unused upper bits stay zero
  // and are pruned as constant flops.
  localparam int MAX_WIDTH = 256;

  // Everything one beat carries between stages: the running carry, the sum
  // bits resolved so far and the operand bits still waiting to be resolved
  // (b already inverted for subtract).
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 ovf;
  } stage_t;

  // Legal geometry: width splits evenly into stages of whole groups
  function automatic bit params_ok(input int width, input int group, input int stages);
    if (width <= 0 || group <= 0 || stages <= 0) return 1'b0;
    if (width > MAX_WIDTH) return 1'b0;
    return (width % (stages * group)) == 0;
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit carry-lookahead cell with group propagate/generate
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             P,
  output logic             G
);

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Carry into each bit of the group from the bit-level P/G terms
  always_comb begin
    w_c    = '0;
    w_c[0] = c_in;
    for (int i = 1; i < GROUP; i++) begin
      w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
    end
  end

  // Group generate: the group produces a carry on its own, independent of c_in
  always_comb begin
    G = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      G = w_g[i] | (w_p[i] & G);
    end
  end

  assign P   = &w_p;
  assign sum = w_p ^ w_c;

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready stream
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int GROUP  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / GROUP;
  localparam logic [MAX_WIDTH-1:0] ONE = MAX_WIDTH'(1);

  if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP and at most MAX_WIDTH");
  end

  stage_t [STAGES-1:0] w_reg;
  stage_t              w_last;
  logic                w_unused;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits below this mask have been consumed once this stage is done
    localparam logic [MAX_WIDTH-1:0] HI_MASK = ~((ONE << ((k + 1) * SEG)) - ONE);
    localparam bit IS_LAST = (k == STAGES - 1);

    stage_t          w_in;
    stage_t          w_nxt;
    stage_t          r_st;
    logic [SEG-1:0]  w_ss;
    logic [NGRP-1:0] w_p;
    logic [NGRP-1:0] w_g;
    logic [NGRP:0]   w_gc;

    if (k == 0) begin : g_head
      // Fresh beat: fold subtract into inverted b and inverted carry-in
      always_comb begin
        w_in              = '0;
        w_in.valid        = in_valid;
        w_in.carry        = cin ^ (sub == OP_SUB);
        w_in.a[WIDTH-1:0] = a;
        w_in.b[WIDTH-1:0] = (sub == OP_SUB) ? ~b : b;
      end
    end else begin : g_body
      assign w_in = w_reg[k-1];
    end

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (w_in.a[k*SEG + j*GROUP +: GROUP]),
        .b    (w_in.b[k*SEG + j*GROUP +: GROUP]),
        .c_in (w_gc[j]),
        .sum  (w_ss[j*GROUP +: GROUP]),
        .P    (w_p[j]),
        .G    (w_g[j])
      );
    end

    // Second-level lookahead: every group carry of this segment from group P/G
    always_comb begin
      w_gc    = '0;
      w_gc[0] = w_in.carry;
      for (int j = 0; j < NGRP; j++) begin
        w_gc[j+1] = w_g[j] | (w_p[j] & w_gc[j]);
      end
    end

    // Payload for the next position; bubbles travel as all-zero payloads
    always_comb begin
      w_nxt = '0;
      if (w_in.valid) begin
        w_nxt                    = w_in;
        w_nxt.a                  = w_in.a & HI_MASK;
        w_nxt.b                  = w_in.b & HI_MASK;
        w_nxt.sum[k*SEG +: SEG]  = w_ss;
        w_nxt.carry              = w_gc[NGRP];
        if (IS_LAST) begin
          w_nxt.ovf = w_in.a[WIDTH-1] ^ w_in.b[WIDTH-1] ^ w_ss[SEG-1] ^ w_gc[NGRP];
        end
      end
    end

    // Stage register: flushed by reset, frozen by the global stall
    always_ff @(posedge clk) begin
      if (rst) begin
        r_st <= '0;
      end else if (in_ready) begin
        r_st <= w_nxt;
      end
    end

    assign w_reg[k] = r_st;
  end

  assign w_last    = w_reg[STAGES-1];
  assign out_valid = w_last.valid;
  assign in_ready  = !out_valid || out_ready;
  assign sum       = w_last.sum[WIDTH-1:0];
  assign cout      = w_last.carry;
  assign ovf       = w_last.ovf;

  // Last-stage operand fields are always empty by then
  assign w_unused = ^{w_last.a, w_last.b, w_last.sum};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;

  localparam int SWEEP_N = 10000;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  logic [15:0] s_a [2];
  logic [15:0] s_b [2];
  logic        s_cin [2];
  logic        s_sub [2];
  logic        s_in_valid [2];
  logic        s_in_ready [2];
  logic        s_out_valid [2];
  logic        s_out_ready [2];
  logic [15:0] s_sum [2];
  logic        s_cout [2];
  logic        s_ovf [2];

  int n_checks;
  int n_err;

  vec_t vecs [10];

  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(gi == 0 ? 2 : 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(s_in_valid[gi]), .in_ready(s_in_ready[gi]),
      .a(s_a[gi]), .b(s_b[gi]), .cin(s_cin[gi]), .sub(s_sub[gi]),
      .out_valid(s_out_valid[gi]), .out_ready(s_out_ready[gi]),
      .sum(s_sum[gi]), .cout(s_cout[gi]), .ovf(s_ovf[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {cout, sum, ovf} for the 16-bit sweep, overflow judged from operand/result signs
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yy;
    logic        cc;
    logic [16:0] t;
    logic        v;
    yy = s ? ~y : y;
    cc = s ? ~c : c;
    t  = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
    v  = (x[15] == yy[15]) && (t[15] != x[15]);
    return {t[16], t[15:0], v};
  endfunction

  // One isolated beat: latency in edges including the accept edge, then the result
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat <= 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, sum, v.s);
    chk({tag, "_cout"}, cout, v.co);
    chk({tag, "_ovf"}, ovf, v.ov);
  endtask

  int          sent;
  int          got;
  int          stalls;
  int          bad;
  int          s_sent [2];
  int          s_got [2];
  logic        s_acc [2];
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];
  logic [17:0] e;

  initial begin
    n_checks = 0;
    n_err    = 0;

    vecs[0] = '{64'd2, 64'd5, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'd2232300, 64'd9890809, 1'b1, 1'b0, 64'd12123110, 1'b0, 1'b0};
    vecs[5] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[9] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_a[i] = '0; s_b[i] = '0; s_cin[i] = 1'b0; s_sub[i] = 1'b0;
      s_in_valid[i] = 1'b0; s_out_ready[i] = 1'b1;
      s_sent[i] = 0; s_got[i] = 0; s_acc[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: six beats streamed, output stalled for three cycles
    sent = 0; got = 0; stalls = 0; bad = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (sent < 6);
      a = 64'(sent); b = 64'(sent); cin = 1'b1; sub = 1'b0;
      #1;
      if (in_ready !== (!out_valid || out_ready)) bad++;
      if (!in_ready) stalls++;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_sum%0d", got), sum, 2 * got + 1);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_beats_out", got, 6);
    chk("bp_ready_rule", bad, 0);
    chk("bp_stall_cycles", stalls, 3);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("bp_no_extra", bad, 0);

    // Reset with three beats in flight and a fourth offered alongside rst
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'(1000 + c); b = 64'd1; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; a = 64'd77;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    bad = 0;
    repeat (8) begin
      #1;
      if (out_valid || sum != 64'd0 || cout || ovf) bad++;
      @(negedge clk);
    end
    chk("rst_flush", bad, 0);
    run_vec('{64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0, 1'b0}, "post_rst");

    // Random sweep on the 16-bit, 2-stage and 1-stage instances
    for (int c = 0; c < 60000 && (s_got[0] < SWEEP_N || s_got[1] < SWEEP_N); c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!s_in_valid[i] || s_acc[i]) begin
          s_in_valid[i] = (s_sent[i] < SWEEP_N) && ($urandom_range(7) != 0);
          s_a[i]   = 16'($urandom);
          s_b[i]   = 16'($urandom);
          s_cin[i] = 1'($urandom);
          s_sub[i] = 1'($urandom);
        end
        s_out_ready[i] = ($urandom_range(3) != 0);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        if (s_out_valid[i] && s_out_ready[i]) begin
          if (i == 0 && q0.size() > 0) e = q0.pop_front();
          else if (i == 1 && q1.size() > 0) e = q1.pop_front();
          else e = 'x;
          chk($sformatf("sweep%0d_beat%0d", i, s_got[i]),
              {s_cout[i], s_sum[i], s_ovf[i]}, e);
          s_got[i]++;
        end
        s_acc[i] = s_in_valid[i] && s_in_ready[i];
        if (s_acc[i]) begin
          if (i == 0) q0.push_back(ref16(s_a[i], s_b[i], s_cin[i], s_sub[i]));
          else        q1.push_back(ref16(s_a[i], s_b[i], s_cin[i], s_sub[i]));
          s_sent[i]++;
        end
      end
    end
    chk("sweep0_count", s_got[0], SWEEP_N);
    chk("sweep1_count", s_got[1], SWEEP_N);
    chk("sweep0_drained", q0.size(), 0);
    chk("sweep1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
